// File: rtl/result_stream_out_if.sv
// Lane-wide valid/ready result stream between the drain stage and the host/DMA.
interface result_stream_out_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/result_stream_out.sv
// Drains the SIMD result RAM after a stop edge, streaming each word lane by lane
// (lane 0 first) with last on the final beat and a done pulse afterwards.
module result_stream_out #(
  parameter int DATA_WIDTH      = 32,
  parameter int PE_ELEMENTS     = 4,
  parameter int DRAM_DEPTH      = 256,
  parameter int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                stop,
  input  logic [DRAM_ADDR_WIDTH:0]            num_words,
  output logic [DRAM_ADDR_WIDTH-1:0]          ram_rd_addr,
  output logic                                ram_rd_en,
  input  logic [DATA_WIDTH*PE_ELEMENTS-1:0]   ram_rd_data,
  result_stream_out_if.master                 m,
  output logic                                busy,
  output logic                                done
);

  localparam int LANE_W = (PE_ELEMENTS > 1) ? $clog2(PE_ELEMENTS) : 1;
  localparam logic [DRAM_ADDR_WIDTH:0] DEPTH_N   = (DRAM_ADDR_WIDTH+1)'(DRAM_DEPTH);
  localparam logic [LANE_W-1:0]        LAST_LANE = LANE_W'(PE_ELEMENTS-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                              r_state;
  logic                                r_stop_q;
  logic [DRAM_ADDR_WIDTH:0]            r_n;
  logic [DRAM_ADDR_WIDTH-1:0]          r_word_idx;
  logic [LANE_W-1:0]                   r_lane;
  logic [DATA_WIDTH*PE_ELEMENTS-1:0]   r_buf;

  logic                                w_start;
  logic [DRAM_ADDR_WIDTH:0]            w_n_clamp;
  logic                                w_last_word;
  logic                                w_last_lane;
  logic [LANE_W-1:0]                   w_next_lane;
  logic                                w_hs;

  assign w_start     = (r_state == S_IDLE) && stop && !r_stop_q;
  assign w_n_clamp   = (num_words > DEPTH_N) ? DEPTH_N : num_words;
  assign w_last_word = ({1'b0, r_word_idx} == (r_n - 1'b1));
  assign w_last_lane = (r_lane == LAST_LANE);
  assign w_next_lane = r_lane + 1'b1;
  assign w_hs        = m.m_valid && m.m_ready;

  // Stream outputs are loaded one beat ahead so m_data/m_last come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stop_q    <= 1'b0;
      r_n         <= '0;
      r_word_idx  <= '0;
      r_lane      <= '0;
      r_buf       <= '0;
      ram_rd_addr <= '0;
      ram_rd_en   <= 1'b0;
      m.m_data    <= '0;
      m.m_valid   <= 1'b0;
      m.m_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_stop_q  <= stop;
      ram_rd_en <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_n        <= w_n_clamp;
            r_word_idx <= '0;
            r_lane     <= '0;
            if (w_n_clamp == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state     <= S_REQ;
              ram_rd_en   <= 1'b1;
              ram_rd_addr <= '0;
              busy        <= 1'b1;
            end
          end
        end
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          r_buf     <= ram_rd_data;
          r_lane    <= '0;
          m.m_valid <= 1'b1;
          m.m_data  <= ram_rd_data[DATA_WIDTH-1:0];
          m.m_last  <= w_last_word && (PE_ELEMENTS == 1);
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            if (!w_last_lane) begin
              r_lane   <= w_next_lane;
              m.m_data <= r_buf[int'(w_next_lane)*DATA_WIDTH +: DATA_WIDTH];
              m.m_last <= w_last_word && (w_next_lane == LAST_LANE);
            end else begin
              m.m_valid <= 1'b0;
              m.m_last  <= 1'b0;
              if (w_last_word) begin
                r_state <= S_DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
              end else begin
                r_word_idx  <= r_word_idx + 1'b1;
                ram_rd_addr <= r_word_idx + 1'b1;
                ram_rd_en   <= 1'b1;
                r_state     <= S_REQ;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_stream_out.sv
// Directed bench for result_stream_out: frame content, timing, backpressure,
// zero-length frames, stop re-arming, mid-frame reset and depth clamping.
module tb_result_stream_out;
  localparam int DW    = 32;
  localparam int PE    = 4;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              stop;
  logic [AW:0]       num_words;
  logic [AW-1:0]     ram_rd_addr;
  logic              ram_rd_en;
  logic [DW*PE-1:0]  ram_rd_data;
  logic              busy;
  logic              done;

  result_stream_out_if #(.DATA_WIDTH(DW)) m_if ();

  result_stream_out #(
    .DATA_WIDTH(DW),
    .PE_ELEMENTS(PE),
    .DRAM_DEPTH(DEPTH),
    .DRAM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stop(stop),
    .num_words(num_words),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_en(ram_rd_en),
    .ram_rd_data(ram_rd_data),
    .m(m_if),
    .busy(busy),
    .done(done)
  );

  // Synchronous result RAM: data appears the cycle after the read enable.
  logic [DW*PE-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor log, sampled on the falling edge.
  logic [DW-1:0] beat_d [$];
  logic          beat_l [$];
  int            addr_q [$];
  int first_valid_cyc, last_hs_cyc, done_cnt, done_cyc, cnt_valid, cnt_rden, cnt_busy;
  logic p_valid, p_ready, p_last;
  logic [DW-1:0] p_data;
  int rdy_mode = 0;
  int rdy_ph   = 0;

  task automatic clear_log();
    beat_d.delete();
    beat_l.delete();
    addr_q.delete();
    first_valid_cyc = -1;
    last_hs_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
    cnt_valid = 0;
    cnt_rden = 0;
    cnt_busy = 0;
    rdy_ph = 0;
  endtask

  initial begin
    p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0; p_data = '0;
    clear_log();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (p_valid && !p_ready) begin
          check_eq("hold_valid", m_if.m_valid, 1'b1);
          check_eq("hold_data", m_if.m_data, p_data);
          check_eq("hold_last", m_if.m_last, p_last);
        end
        if (m_if.m_valid) begin
          cnt_valid++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (m_if.m_valid && m_if.m_ready) begin
          beat_d.push_back(m_if.m_data);
          beat_l.push_back(m_if.m_last);
          last_hs_cyc = cyc;
        end
        if (ram_rd_en) begin
          cnt_rden++;
          addr_q.push_back(int'(ram_rd_addr));
        end
        if (busy) cnt_busy++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
      p_valid = rst ? 1'b0 : m_if.m_valid;
      p_ready = m_if.m_ready;
      p_last  = m_if.m_last;
      p_data  = m_if.m_data;
    end
  end

  // Ready driver: mode 0 holds ready high, mode 1 repeats 1,0,0.
  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) m_if.m_ready = 1'b1;
      else begin
        m_if.m_ready = (rdy_ph == 0);
        rdy_ph = (rdy_ph + 1) % 3;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0;

  task automatic start_frame(input int nw);
    @(posedge clk); #1;
    stop = 1'b0;
    @(posedge clk); #1;
    num_words = (AW+1)'(nw);
    stop = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq({tag, "_done_seen"}, done_cnt > 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify_frame(input string tag, input int nw);
    int nb;
    int exp_beats = nw * PE;
    logic [DW*PE-1:0] wv;
    check_eq({tag, "_beats"}, beat_d.size(), exp_beats);
    nb = (beat_d.size() < exp_beats) ? beat_d.size() : exp_beats;
    for (int i = 0; i < nb; i++) begin
      wv = mem[i / PE];
      check_eq($sformatf("%s_data%0d", tag, i), beat_d[i], wv[(i % PE)*DW +: DW]);
      check_eq($sformatf("%s_last%0d", tag, i), beat_l[i], i == exp_beats - 1);
    end
    check_eq({tag, "_nreads"}, addr_q.size(), nw);
    for (int i = 0; i < addr_q.size() && i < nw; i++)
      check_eq($sformatf("%s_addr%0d", tag, i), addr_q[i], i);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    rst = 1'b1;
    stop = 1'b0;
    num_words = '0;
    mem[0] = {32'h44, 32'h33, 32'h22, 32'h11};
    mem[1] = {32'h88, 32'h77, 32'h66, 32'h55};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_en", ram_rd_en, 1'b0);
    check_eq("rst_rd_addr", ram_rd_addr, 0);
    check_eq("rst_valid", m_if.m_valid, 1'b0);
    check_eq("rst_data", m_if.m_data, 0);
    check_eq("rst_last", m_if.m_last, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    rst = 1'b0;

    // Two words, ready high.
    clear_log();
    rdy_mode = 0;
    start_frame(2);
    wait_done("t1", 100);
    verify_frame("t1", 2);
    check_eq("t1_first_valid_lat", first_valid_cyc - t0, 3);
    check_eq("t1_done_lat", done_cyc - t0, 13);
    check_eq("t1_done_after_hs", done_cyc - last_hs_cyc, 1);

    // Same data under 1,0,0 backpressure; hold checks run in the monitor.
    clear_log();
    rdy_mode = 1;
    start_frame(2);
    wait_done("t2", 200);
    verify_frame("t2", 2);
    rdy_mode = 0;

    // Zero-length frame.
    clear_log();
    start_frame(0);
    wait_done("t3", 20);
    check_eq("t3_done_lat", done_cyc - t0, 1);
    check_eq("t3_done_cnt", done_cnt, 1);
    check_eq("t3_valid_cnt", cnt_valid, 0);
    check_eq("t3_rden_cnt", cnt_rden, 0);
    check_eq("t3_busy_cnt", cnt_busy, 0);

    // Stop stays high: no new frame until it is dropped and re-raised.
    clear_log();
    num_words = 9'd2;
    repeat (50) @(posedge clk);
    #1;
    check_eq("t4_idle_rden", cnt_rden, 0);
    check_eq("t4_idle_valid", cnt_valid, 0);
    check_eq("t4_idle_done", done_cnt, 0);
    start_frame(2);
    wait_done("t4", 100);
    verify_frame("t4", 2);

    // Reset during lane 2 of word 0.
    clear_log();
    start_frame(2);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t5_pre_valid", m_if.m_valid, 1'b1);
    check_eq("t5_pre_lane2", m_if.m_data, 32'h33);
    rst = 1'b1;
    stop = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_rst_valid", m_if.m_valid, 1'b0);
    check_eq("t5_rst_busy", busy, 1'b0);
    check_eq("t5_rst_done", done, 1'b0);
    check_eq("t5_rst_last", m_if.m_last, 1'b0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t5_no_done", done_cnt, 0);
    clear_log();
    start_frame(2);
    wait_done("t5", 100);
    check_eq("t5_restart_addr0", (addr_q.size() > 0) ? addr_q[0] : -1, 0);
    verify_frame("t5", 2);

    // Oversized request is clamped to the full RAM depth.
    for (int w = 0; w < DEPTH; w++)
      for (int l = 0; l < PE; l++)
        mem[w][l*DW +: DW] = 32'hA000_0000 | 32'(w * 16 + l);
    clear_log();
    start_frame(300);
    wait_done("t6", 3000);
    verify_frame("t6", DEPTH);
    check_eq("t6_last_addr", (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : -1, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
